// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signal bundle for the UART TX scheduler.
// master = scheduler side, slave = byte sources plus transmitter side.
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
);
    logic               en;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   cfg_n_parity;
    logic [N_REQ-1:0]   cfg_ev_parity;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   req_done;
    logic [N_REQ-1:0]   req_err;
    logic               utx_en;
    logic               utx_start;
    logic [7:0]         utx_data;
    logic               utx_n_parity;
    logic               utx_ev_parity;
    logic               utx_done;
    logic               busy;
    logic [2:0]         grant_id;

    modport master (
        input  en, req_valid, req_data, cfg_n_parity, cfg_ev_parity, utx_done,
        output req_ready, req_done, req_err, utx_en, utx_start, utx_data,
               utx_n_parity, utx_ev_parity, busy, grant_id
    );

    modport slave (
        output en, req_valid, req_data, cfg_n_parity, cfg_ev_parity, utx_done,
        input  req_ready, req_done, req_err, utx_en, utx_start, utx_data,
               utx_n_parity, utx_ev_parity, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin share of one UART transmitter among N_REQ byte sources; accept in IDLE, start pulse next cycle.
// Sources are backpressured (req_ready low) outside IDLE, while en is low, and during the inter-frame gap.
module uart_tx_sched #(
    parameter int N_REQ      = 4,
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic            baud_clk,
    input  logic            rst,
    uart_tx_sched_if.master bus
);
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    gid_q, gid_d;
    logic [7:0]       data_q, data_d;
    logic             n_par_q, n_par_d;
    logic             ev_par_q, ev_par_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic [N_REQ-1:0] ready;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(rr_ptr_q) + i) % N_REQ);
            if (!win_vld && bus.req_valid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        gid_d    = gid_q;
        data_d   = data_q;
        n_par_d  = n_par_q;
        ev_par_d = ev_par_q;
        done_d   = '0;
        err_d    = '0;
        ready    = '0;
        case (state_q)
            IDLE: begin
                if (bus.en && win_vld && !rst) begin
                    ready[win_idx] = 1'b1;
                    gid_d          = win_idx;
                    rr_ptr_d       = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
                    data_d         = bus.req_data[{win_idx, 3'b000} +: 8];
                    n_par_d        = bus.cfg_n_parity[win_idx];
                    ev_par_d       = bus.cfg_ev_parity[win_idx];
                    state_d        = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (bus.utx_done) begin
                    done_d[gid_q] = 1'b1;
                    cnt_d         = '0;
                    state_d       = GAP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d[gid_q] = 1'b1;
                    cnt_d        = '0;
                    state_d      = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            data_q   <= '0;
            n_par_q  <= 1'b1;
            ev_par_q <= 1'b0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            data_q   <= data_d;
            n_par_q  <= n_par_d;
            ev_par_q <= ev_par_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready     = ready;
    assign bus.req_done      = done_q;
    assign bus.req_err       = err_q;
    assign bus.utx_en        = ~rst;
    assign bus.utx_start     = (state_q == START);
    assign bus.utx_data      = data_q;
    assign bus.utx_n_parity  = n_par_q;
    assign bus.utx_ev_parity = ev_par_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.grant_id      = 3'(gid_q);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: N_REQ=4, TIMEOUT=16, GAP_CYCLES=1.
module tb_uart_tx_sched;
    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int GAP = 1;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched_if #(.N_REQ(N)) bus();

    uart_tx_sched #(.N_REQ(N), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .baud_clk (clk),
        .rst      (rst),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int t);
        int n;
        n = 0;
        while (bus.req_ready == '0 && n < 60) begin
            step();
            #1;
            n++;
        end
        check("ready_seen", 32'(|bus.req_ready), 32'd1);
        t = cyc;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready),     32'h0);
        check({tag, "_done"},  32'(bus.req_done),      32'h0);
        check({tag, "_err"},   32'(bus.req_err),       32'h0);
        check({tag, "_start"}, 32'(bus.utx_start),     32'h0);
        check({tag, "_data"},  32'(bus.utx_data),      32'h0);
        check({tag, "_npar"},  32'(bus.utx_n_parity),  32'h1);
        check({tag, "_evpar"}, 32'(bus.utx_ev_parity), 32'h0);
        check({tag, "_busy"},  32'(bus.busy),          32'h0);
        check({tag, "_gid"},   32'(bus.grant_id),      32'h0);
        check({tag, "_uen"},   32'(bus.utx_en),        32'h1);
    endtask

    initial begin
        int t, t2, e, prev, n;
        logic [3:0] acc;

        rst               = 1'b1;
        bus.en            = 1'b0;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.cfg_n_parity  = '0;
        bus.cfg_ev_parity = '0;
        bus.utx_done      = 1'b0;
        prev              = 0;

        // Reset state
        step();
        #1;
        check("uen_in_rst", 32'(bus.utx_en), 32'h0);
        step();
        rst = 1'b0;
        #1;
        check_reset_vals("rst");

        // Single request, requester 2, 0xA5, even parity
        step();
        bus.en            = 1'b1;
        bus.req_valid     = 4'b0100;
        bus.req_data      = 32'h00A5_0000;
        bus.cfg_n_parity  = 4'b0000;
        bus.cfg_ev_parity = 4'b0100;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'b0100);
        step();
        bus.req_valid = '0;
        bus.req_data  = '0;
        #1;
        check("single_start", 32'(bus.utx_start),     32'h1);
        check("single_data",  32'(bus.utx_data),      32'hA5);
        check("single_npar",  32'(bus.utx_n_parity),  32'h0);
        check("single_evpar", 32'(bus.utx_ev_parity), 32'h1);
        check("single_gid",   32'(bus.grant_id),      32'h2);
        check("single_busy",  32'(bus.busy),          32'h1);
        check("single_nordy", 32'(bus.req_ready),     32'h0);
        acc = '0;
        for (int k = 1; k <= 10; k++) begin
            step();
            #1;
            acc = acc | bus.req_done | bus.req_err | {3'b000, bus.utx_start};
        end
        check("single_quiet", 32'(acc), 32'h0);
        step();
        bus.utx_done = 1'b1;
        #1;
        check("single_wait_busy", 32'(bus.busy), 32'h1);
        step();
        bus.utx_done = 1'b0;
        #1;
        check("single_done", 32'(bus.req_done), 32'b0100);
        check("single_noerr", 32'(bus.req_err), 32'h0);
        step();
        #1;
        check("single_done_once", 32'(bus.req_done), 32'h0);
        check("single_idle", 32'(bus.busy), 32'h0);

        // Reset so round robin starts at requester 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;

        // Round robin, all four valid, transmitter answers one cycle after WAIT begins
        bus.req_valid    = 4'b1111;
        bus.req_data     = 32'h4433_2211;
        bus.cfg_n_parity = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            wait_ready(t);
            check("rr_grant", 32'(bus.req_ready), 32'(1 << (g % 4)));
            if (g > 0) check("rr_spacing", 32'(t - prev), 32'(4 + GAP));
            prev = t;
            step();
            if (g == 4) bus.req_valid = '0;
            #1;
            check("rr_data", 32'(bus.utx_data), 32'(8'h11 * (g % 4 + 1)));
            step();
            step();
            bus.utx_done = 1'b1;
            step();
            bus.utx_done = 1'b0;
            #1;
            check("rr_done", 32'(bus.req_done), 32'(1 << (g % 4)));
            step();
            #1;
        end

        // Timeout on requester 1
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_5A00;
        #1;
        wait_ready(t);
        check("to_grant", 32'(bus.req_ready), 32'b0010);
        step();
        bus.req_valid = '0;
        #1;
        n   = 0;
        acc = '0;
        while (bus.req_err == '0 && n < 40) begin
            step();
            #1;
            acc = acc | bus.req_done;
            n++;
        end
        e = cyc;
        check("to_err",     32'(bus.req_err), 32'b0010);
        check("to_latency", 32'(e - t),       32'(TO + 2));
        check("to_no_done", 32'(acc),         32'h0);
        bus.req_valid = 4'b0001;
        #1;
        check("to_gap_no_ready", 32'(bus.req_ready), 32'h0);
        step();
        #1;
        check("to_next_grant", 32'(bus.req_ready), 32'b0001);
        check("to_next_delay", 32'(cyc - e),       32'(GAP));

        // Done lands on the last WAIT cycle of the timeout window
        step();
        bus.req_valid = '0;
        #1;
        for (int k = 0; k < TO; k++) step();
        bus.utx_done = 1'b1;
        step();
        bus.utx_done = 1'b0;
        #1;
        check("coll_done",  32'(bus.req_done), 32'b0001);
        check("coll_noerr", 32'(bus.req_err),  32'h0);
        step();
        #1;
        check("coll_err_later", 32'(bus.req_err), 32'h0);

        // Enable gating
        bus.en            = 1'b0;
        bus.req_valid     = 4'b0100;
        bus.req_data      = 32'h003C_0000;
        bus.cfg_n_parity  = 4'b0000;
        bus.cfg_ev_parity = 4'b0000;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            acc = acc | bus.req_ready;
            step();
        end
        #1;
        check("en_off_no_ready", 32'(acc),      32'h0);
        check("en_off_idle",     32'(bus.busy), 32'h0);
        bus.en = 1'b1;
        #1;
        check("en_on_grant", 32'(bus.req_ready), 32'b0100);
        step();
        bus.req_valid = '0;
        #1;
        check("en_odd_npar",  32'(bus.utx_n_parity),  32'h0);
        check("en_odd_evpar", 32'(bus.utx_ev_parity), 32'h0);
        step();
        bus.en            = 1'b0;
        bus.req_valid     = 4'b1000;
        bus.req_data      = 32'h7E00_0000;
        bus.cfg_n_parity  = 4'b1000;
        step();
        step();
        bus.utx_done = 1'b1;
        step();
        bus.utx_done = 1'b0;
        #1;
        check("en_inflight_done", 32'(bus.req_done), 32'b0100);
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            acc = acc | bus.req_ready;
        end
        check("en_off_pending", 32'(acc),      32'h0);
        check("en_off_idle2",   32'(bus.busy), 32'h0);
        bus.en = 1'b1;
        #1;
        check("en_regrant", 32'(bus.req_ready), 32'b1000);

        // Reset while requester 3 is in WAIT
        step();
        bus.req_valid = '0;
        #1;
        check("r3_data", 32'(bus.utx_data), 32'h7E);
        step();
        step();
        #1;
        check("r3_busy", 32'(bus.busy),     32'h1);
        check("r3_gid",  32'(bus.grant_id), 32'h3);
        rst = 1'b1;
        #1;
        check("r3_uen_rst", 32'(bus.utx_en), 32'h0);
        step();
        rst = 1'b0;
        #1;
        check_reset_vals("r3_rst");
        bus.utx_done = 1'b1;
        step();
        bus.utx_done = 1'b0;
        acc = '0;
        for (int k = 0; k < TO + 4; k++) begin
            #1;
            acc = acc | bus.req_done | bus.req_err | bus.req_ready | {3'b000, bus.utx_start};
            step();
        end
        #1;
        check("r3_no_pulse", 32'(acc),      32'h0);
        check("r3_idle",     32'(bus.busy), 32'h0);
        bus.req_valid = 4'b1001;
        #1;
        check("r3_grant_from0", 32'(bus.req_ready), 32'b0001);
        step();
        bus.req_valid = '0;
        #1;
        check("r3_gid0", 32'(bus.grant_id), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
